vbus_arbiter: RTL and testbench

VBUS_ARBITER -- requirements
Module: vbus_arbiter

---
 rtl/vbus_arbiter_pkg.sv | 30 +++
 rtl/vbus_arbiter.sv | 145 ++++++++++++++
 tb/tb_vbus_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vbus_arbiter_pkg.sv
// rtl/vbus_arbiter_pkg.sv - shared VRAM bus arbitration types, owner codes and parameter defaults
package vbus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TURN = 3'd1,
        ST_VGA  = 3'd2,
        ST_DMA  = 3'd3,
        ST_CPU  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    localparam int unsigned MAX_BURST_DEF   = 16;
    localparam int unsigned CPU_SLOT_DEF    = 2;
    localparam int unsigned TURN_CYCLES_DEF = 1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vbus_arbiter.sv
// rtl/vbus_arbiter.sv - VRAM bus arbiter between VGA scanout, VGA DMA and CPU with turnaround gaps
module vbus_arbiter
    import vbus_arbiter_pkg::*;
#(
    parameter int unsigned MaxBurst   = MAX_BURST_DEF,
    parameter int unsigned CpuSlot    = CPU_SLOT_DEF,
    parameter int unsigned TurnCycles = TURN_CYCLES_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_b,
    input  logic       i_vga_req_b,
    input  logic       i_dma_req,
    input  logic       i_cpu_req_b,
    output logic       o_vga_grant_b,
    output logic       o_free_vbus_b,
    output logic       o_cpu_grant_b,
    output logic       o_cpu_ack_b,
    output logic [1:0] o_owner
);

    localparam int unsigned CntMax = max3(MaxBurst, CpuSlot, TurnCycles);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef logic [CntW-1:0] cnt_t;

    // Loads are one less than the length so the final cycle of a phase sees zero
    localparam cnt_t TurnLoad  = cnt_t'(TurnCycles - 1);
    localparam cnt_t CpuLoad   = cnt_t'(CpuSlot - 1);
    localparam cnt_t BurstLoad = cnt_t'(MaxBurst - 1);

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   vga_req, dma_req, cpu_req, cnt_zero;

    logic   vga_grant_b_q, free_vbus_q, cpu_grant_b_q, cpu_ack_b_q;
    owner_e owner_q, owner_d;

    assign vga_req  = ~i_vga_req_b;
    assign dma_req  = i_dma_req;
    assign cpu_req  = ~i_cpu_req_b;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (vga_req || dma_req || cpu_req) begin
                    state_d = ST_TURN;
                    cnt_d   = TurnLoad;
                end
            end
            ST_TURN: begin
                if (cnt_zero) begin
                    if (vga_req) begin
                        state_d = ST_VGA;
                        cnt_d   = '0;
                    end else if (cpu_req) begin
                        state_d = ST_CPU;
                        cnt_d   = CpuLoad;
                    end else if (dma_req) begin
                        state_d = ST_DMA;
                        cnt_d   = BurstLoad;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_VGA: begin
                if (!vga_req) begin
                    state_d = ST_TURN;
                    cnt_d   = TurnLoad;
                end
            end
            ST_DMA: begin
                // Counter saturates at zero: the burst only ends early once a CPU request shows up
                if (vga_req || !dma_req || (cpu_req && cnt_zero)) begin
                    state_d = ST_TURN;
                    cnt_d   = TurnLoad;
                end else if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CPU: begin
                if (vga_req || cnt_zero) begin
                    state_d = ST_TURN;
                    cnt_d   = TurnLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        owner_d = OWN_NONE;
        case (state_d)
            ST_VGA:  owner_d = OWN_VGA;
            ST_DMA:  owner_d = OWN_DMA;
            ST_CPU:  owner_d = OWN_CPU;
            default: owner_d = OWN_NONE;
        endcase
    end

    // Outputs are flopped from the next state so they align with the state they describe
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            vga_grant_b_q <= 1'b1;
            free_vbus_q   <= 1'b0;
            cpu_grant_b_q <= 1'b1;
            cpu_ack_b_q   <= 1'b1;
            owner_q       <= OWN_NONE;
        end else begin
            vga_grant_b_q <= (state_d != ST_VGA);
            free_vbus_q   <= (state_d == ST_DMA);
            cpu_grant_b_q <= (state_d != ST_CPU);
            cpu_ack_b_q   <= !((state_d == ST_CPU) && (cnt_d == '0));
            owner_q       <= owner_d;
        end
    end

    assign o_vga_grant_b = vga_grant_b_q;
    assign o_free_vbus_b = free_vbus_q;
    assign o_cpu_grant_b = cpu_grant_b_q;
    assign o_cpu_ack_b   = cpu_ack_b_q;
    assign o_owner       = owner_q;

endmodule

// File: tb/tb_vbus_arbiter.sv
// tb/tb_vbus_arbiter.sv - directed vector bench for vbus_arbiter
module tb_vbus_arbiter;

    logic       clk;
    logic       rst_b;
    logic       vga_req_b;
    logic       dma_req;
    logic       cpu_req_b;
    logic       vga_grant_b;
    logic       free_vbus_b;
    logic       cpu_grant_b;
    logic       cpu_ack_b;
    logic [1:0] owner;

    int checks;
    int errors;

    // {owner, vga_grant_b, free_vbus_b, cpu_grant_b, cpu_ack_b}
    localparam logic [5:0] E_NONE = 6'b00_1011;
    localparam logic [5:0] E_VGA  = 6'b01_0011;
    localparam logic [5:0] E_DMA  = 6'b10_1111;
    localparam logic [5:0] E_CPU  = 6'b11_1001;
    localparam logic [5:0] E_CPUA = 6'b11_1000;

    typedef struct {
        logic       vga_b;
        logic       dma;
        logic       cpu_b;
        logic [5:0] exp;
    } vec_t;

    vbus_arbiter dut (
        .i_clk         (clk),
        .i_rst_b       (rst_b),
        .i_vga_req_b   (vga_req_b),
        .i_dma_req     (dma_req),
        .i_cpu_req_b   (cpu_req_b),
        .o_vga_grant_b (vga_grant_b),
        .o_free_vbus_b (free_vbus_b),
        .o_cpu_grant_b (cpu_grant_b),
        .o_cpu_ack_b   (cpu_ack_b),
        .o_owner       (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {owner, vga_grant_b, free_vbus_b, cpu_grant_b, cpu_ack_b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        int n;
        @(posedge clk);
        #1;
        n = int'(!vga_grant_b) + int'(free_vbus_b) + int'(!cpu_grant_b);
        check("one_grant", 32'(n <= 1), 32'd1);
    endtask

    task automatic idle_inputs();
        vga_req_b = 1'b1;
        dma_req   = 1'b0;
        cpu_req_b = 1'b1;
    endtask

    vec_t vecs[19];
    int   n;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, E_NONE};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, E_VGA};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, E_VGA};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, E_NONE};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, E_CPU};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, E_CPUA};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, E_NONE};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, E_DMA};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, E_NONE};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, E_NONE};
        vecs[10] = '{1'b1, 1'b0, 1'b1, E_NONE};
        vecs[11] = '{1'b1, 1'b1, 1'b1, E_NONE};
        vecs[12] = '{1'b0, 1'b1, 1'b1, E_VGA};
        vecs[13] = '{1'b1, 1'b1, 1'b1, E_NONE};
        vecs[14] = '{1'b1, 1'b1, 1'b1, E_DMA};
        vecs[15] = '{1'b0, 1'b1, 1'b1, E_NONE};
        vecs[16] = '{1'b0, 1'b1, 1'b1, E_VGA};
        vecs[17] = '{1'b1, 1'b0, 1'b1, E_NONE};
        vecs[18] = '{1'b1, 1'b0, 1'b1, E_NONE};

        // Reset held with every requester active
        rst_b     = 1'b0;
        vga_req_b = 1'b0;
        dma_req   = 1'b1;
        cpu_req_b = 1'b0;
        repeat (3) cyc();
        check("reset_outputs", outs(), E_NONE);
        check("reset_cnt", 32'(dut.cnt_q), 32'd0);
        rst_b = 1'b1;
        cyc();
        check("post_reset_turn", outs(), E_NONE);
        cyc();
        check("post_reset_vga", outs(), E_VGA);
        idle_inputs();
        cyc();
        check("post_reset_release_turn", outs(), E_NONE);
        cyc();
        check("post_reset_idle", outs(), E_NONE);

        // Cycle-by-cycle vectors: simultaneous requests, sampling at TURN end, DMA preemption
        for (int i = 0; i < 19; i++) begin
            vga_req_b = vecs[i].vga_b;
            dma_req   = vecs[i].dma;
            cpu_req_b = vecs[i].cpu_b;
            cyc();
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // DMA alone: unbounded burst
        idle_inputs();
        dma_req = 1'b1;
        cyc();
        check("dma_only_turn", outs(), E_NONE);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (outs() == E_DMA) n++;
        end
        check("dma_only_len", n, 40);
        dma_req = 1'b0;
        cyc();
        check("dma_only_end_turn", outs(), E_NONE);
        cyc();
        check("dma_only_idle", outs(), E_NONE);

        // DMA fairness: CPU shows up on burst cycle 5
        dma_req = 1'b1;
        cyc();
        check("fair_turn", outs(), E_NONE);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (!free_vbus_b) break;
            n++;
            if (n == 5) cpu_req_b = 1'b0;
        end
        check("fair_burst_len", n, 16);
        check("fair_gap", outs(), E_NONE);
        cyc();
        check("fair_cpu1", outs(), E_CPU);
        cyc();
        check("fair_cpu2_ack", outs(), E_CPUA);
        cpu_req_b = 1'b1;
        cyc();
        check("fair_gap2", outs(), E_NONE);
        cyc();
        check("fair_dma_resume", outs(), E_DMA);
        dma_req = 1'b0;
        cyc();
        check("fair_end_turn", outs(), E_NONE);
        cyc();
        check("fair_idle", outs(), E_NONE);

        // VGA preempts a CPU slot; slot is retried in full afterwards
        cpu_req_b = 1'b0;
        cyc();
        check("pre_turn", outs(), E_NONE);
        cyc();
        check("pre_cpu1", outs(), E_CPU);
        vga_req_b = 1'b0;
        cyc();
        check("pre_turn_no_ack", outs(), E_NONE);
        cyc();
        check("pre_vga", outs(), E_VGA);
        cyc();
        check("pre_vga_hold", outs(), E_VGA);
        vga_req_b = 1'b1;
        cyc();
        check("pre_release_turn", outs(), E_NONE);
        cyc();
        check("pre_retry_cpu1", outs(), E_CPU);
        cyc();
        check("pre_retry_ack", outs(), E_CPUA);
        cpu_req_b = 1'b1;
        cyc();
        check("pre_end_turn", outs(), E_NONE);
        cyc();
        check("pre_idle", outs(), E_NONE);

        // Async reset in the middle of a DMA burst
        dma_req = 1'b1;
        cyc();
        check("ar_turn", outs(), E_NONE);
        repeat (7) cyc();
        check("ar_dma7", outs(), E_DMA);
        #2;
        rst_b = 1'b0;
        #1;
        check("ar_free_dropped", outs(), E_NONE);
        check("ar_cnt_zero", 32'(dut.cnt_q), 32'd0);
        #1;
        rst_b = 1'b1;
        check("ar_cnt_after_release", 32'(dut.cnt_q), 32'd0);
        cyc();
        check("ar_release_turn", outs(), E_NONE);
        cyc();
        check("ar_dma_again", outs(), E_DMA);
        dma_req = 1'b0;
        cyc();
        check("ar_end_turn", outs(), E_NONE);
        cyc();
        check("ar_idle", outs(), E_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
